// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-indexed data memory.
// Sub-word stores are read-modify-write; bad accesses return an error and never touch memory.
//
// state  | meaning
// IDLE   | ready for a request; fields and error flag latched on accept
// ACCESS | one memory cycle: load read, word write, or read for merge
// WRITE  | write back the merged word of a sub-word store
// RESP   | one-cycle response pulse
module load_store_unit #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [29:0] idx_q, idx_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merged_q, merged_d;

    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged_word;
    logic        mem_read, mem_write, rsp_valid;
    logic [31:0] mem_wdata;

    always_comb begin
        req_err = 1'b0;
        case (req_size_i)
            SZ_ILL:  req_err = 1'b1;
            SZ_HALF: req_err = req_addr_i[0];
            SZ_WORD: req_err = |req_addr_i[1:0];
            default: req_err = 1'b0;
        endcase
        if ({2'b00, req_addr_i[31:2]} >= DEPTH_L) begin
            req_err = 1'b1;
        end
    end

    // Lane selection from the word currently presented by memory.
    always_comb begin
        byte_sel = mem_rdata_i[7:0];
        case (off_q)
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    end

    always_comb begin
        load_ext = mem_rdata_i;
        case (size_q)
            SZ_BYTE: load_ext = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_ext = {{16{~unsigned_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        merged_word = mem_rdata_i;
        if (size_q == SZ_BYTE) begin
            case (off_q)
                2'd0:    merged_word[7:0]   = wdata_q[7:0];
                2'd1:    merged_word[15:8]  = wdata_q[7:0];
                2'd2:    merged_word[23:16] = wdata_q[7:0];
                default: merged_word[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged_word[31:16] = wdata_q[15:0];
        end else begin
            merged_word[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        idx_d      = idx_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        merged_d   = merged_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = 32'h0;
        rsp_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    write_d    = req_write_i;
                    size_d     = req_size_i;
                    unsigned_d = req_unsigned_i;
                    idx_d      = req_addr_i[31:2];
                    off_d      = req_addr_i[1:0];
                    wdata_d    = req_wdata_i;
                    err_d      = req_err;
                    rdata_d    = 32'h0;
                    state_d    = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    mem_read = 1'b1;
                    rdata_d  = load_ext;
                    state_d  = RESP;
                end else if (size_q == SZ_WORD) begin
                    mem_write = 1'b1;
                    mem_wdata = wdata_q;
                    state_d   = RESP;
                end else begin
                    mem_read = 1'b1;
                    merged_d = merged_word;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_wdata = merged_q;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            idx_q      <= 30'h0;
            off_q      <= 2'b00;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            merged_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            idx_q      <= idx_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            merged_q   <= merged_d;
        end
    end

    // State resets asynchronously, so mem_write falls the instant rst_ni does.
    assign req_ready_o = (state_q == IDLE) & rst_ni;
    assign rsp_valid_o = rsp_valid;
    assign rsp_rdata_o = rsp_valid ? rdata_q : 32'h0;
    assign rsp_err_o   = rsp_valid & err_q;
    assign mem_read_o  = mem_read;
    assign mem_write_o = mem_write;
    assign mem_wdata_o = mem_wdata;
    assign mem_addr_o  = {2'b00, idx_q};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory
// and a response scoreboard filled when each request is driven.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(64)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_size_i(req_size),
        .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // Word memory; mem_init loads a known pattern before the first request.
    logic [31:0] mem [0:63];
    logic        mem_init = 1'b1;
    assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
            mem[3] <= 32'h8899AABB;
        end else if (mem_write && mem_addr < 32'd64) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int rsp_cyc = 0;
    int n_acc = 0;
    int n_rsp = 0;
    int n_rd = 0;
    int n_wr = 0;
    logic [31:0] last_rd_addr = 32'h0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle monitor sampled mid-cycle: handshakes, memory activity, responses.
    always @(negedge clk) begin
        exp_t e;
        chk("rd_wr_overlap", {31'b0, mem_read & mem_write}, 32'h0);
        if (!mem_write) chk("wdata_idle_zero", mem_wdata, 32'h0);
        if (req_valid && req_ready) begin
            n_acc++;
            accept_cyc = cyc;
        end
        if (mem_read) begin
            n_rd++;
            last_rd_addr = mem_addr;
        end
        if (mem_write) begin
            n_wr++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
        end
        if (rsp_valid) begin
            n_rsp++;
            rsp_cyc = cyc;
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'h1, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                chk("rsp_latency", 32'(cyc - accept_cyc), 32'(e.lat));
            end
        end
    end

    task automatic wait_ready(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({tag, "_ready_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
    endtask

    task automatic push_exp(input logic [31:0] rd, input logic er, input int lat);
        exp_t e;
        e.rdata = rd; e.err = er; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input logic [31:0] exp_wd);
        int lat, erd, ewr, rd0, wr0, tgt;
        bit ok;
        if (exp_err) begin
            lat = 1; erd = 0; ewr = 0;
        end else if (!w) begin
            lat = 2; erd = 1; ewr = 0;
        end else if (sz == 2'b10) begin
            lat = 2; erd = 0; ewr = 1;
        end else begin
            lat = 3; erd = 1; ewr = 1;
        end
        rd0 = n_rd; wr0 = n_wr; tgt = n_rsp + 1;
        @(posedge clk); #1;
        drive(w, sz, u, a, wd);
        push_exp(exp_rd, exp_err, lat);
        wait_ready(tag, ok);
        if (!ok) begin
            req_valid = 1'b0;
            void'(sb_q.pop_back());
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (n_rsp >= tgt) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_rsp_seen"}, {31'b0, ok}, 32'h1);
        chk({tag, "_read_cycles"}, 32'(n_rd - rd0), 32'(erd));
        chk({tag, "_write_cycles"}, 32'(n_wr - wr0), 32'(ewr));
        if (erd != 0) chk({tag, "_read_addr"}, last_rd_addr, {2'b00, a[31:2]});
        if (ewr != 0) begin
            chk({tag, "_write_addr"}, last_wr_addr, {2'b00, a[31:2]});
            chk({tag, "_write_data"}, last_wr_data, exp_wd);
        end
    endtask

    initial begin
        bit ok;
        int rsp0, acc0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'b0, req_ready}, 32'h1);

        // Loads from word 3 = 0x8899AABB
        do_req("lb_0d",  1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 32'hFFFFFFAA, 1'b0, 32'h0);
        do_req("lbu_0d", 1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 32'h000000AA, 1'b0, 32'h0);
        do_req("lhu_0e", 1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 32'h00008899, 1'b0, 32'h0);
        do_req("lh_0e",  1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 32'hFFFF8899, 1'b0, 32'h0);

        // Stores
        do_req("sb_0e", 1'b1, 2'b00, 1'b0, 32'h0E, 32'hFFFFFF11, 32'h0, 1'b0, 32'h8811AABB);
        chk("sb_0e_mem", mem[3], 32'h8811AABB);
        do_req("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 32'hDEADBEEF);
        do_req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0);
        do_req("sh_02", 1'b1, 2'b01, 1'b0, 32'h02, 32'hABCD1234, 32'h0, 1'b0, 32'h1234_0000);
        do_req("lb_03", 1'b0, 2'b00, 1'b0, 32'h03, 32'h0, 32'h00000012, 1'b0, 32'h0);
        do_req("lh_0c", 1'b0, 2'b01, 1'b0, 32'h0C, 32'h0, 32'hFFFFAABB, 1'b0, 32'h0);

        // Errors
        do_req("err_lh_0d",  1'b0, 2'b01, 1'b0, 32'h0D,  32'h0, 32'h0, 1'b1, 32'h0);
        do_req("err_lw_02",  1'b0, 2'b10, 1'b0, 32'h02,  32'h0, 32'h0, 1'b1, 32'h0);
        do_req("err_sw_100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h55555555, 32'h0, 1'b1, 32'h0);
        do_req("err_sz11",   1'b1, 2'b11, 1'b0, 32'h10,  32'h66666666, 32'h0, 1'b1, 32'h0);
        do_req("lw_0fc",     1'b0, 2'b10, 1'b0, 32'hFC,  32'h0, 32'hC0DE003F, 1'b0, 32'h0);
        chk("err_mem3", mem[3], 32'h8811AABB);
        chk("err_mem4", mem[4], 32'hDEADBEEF);
        chk("err_mem63", mem[63], 32'hC0DE003F);

        // Reset during the WRITE cycle of a byte store
        rsp0 = n_rsp;
        @(posedge clk); #1;
        drive(1'b1, 2'b00, 1'b0, 32'h0E, 32'h22);
        wait_ready("rst_sb", ok);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_sb_in_write", {31'b0, mem_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_sb_write_drop", {31'b0, mem_write}, 32'h0);
        chk("rst_sb_wdata_drop", mem_wdata, 32'h0);
        chk("rst_sb_ready_low", {31'b0, req_ready}, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sb_no_rsp", 32'(n_rsp - rsp0), 32'h0);
        chk("rst_sb_mem_kept", mem[3], 32'h8811AABB);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_sb_ready_after", {31'b0, req_ready}, 32'h1);

        // Back-to-back loads with req_valid held high
        acc0 = n_acc;
        rsp0 = n_rsp;
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        push_exp(32'hDEADBEEF, 1'b0, 2);
        for (int k = 0; k < 3; k++) begin
            wait_ready("b2b", ok);
            if (!ok) break;
            #1;
            if (k > 0) chk("b2b_idle_gap", 32'(accept_cyc - rsp_cyc), 32'h1);
            @(posedge clk); #1;
            if (k == 0) begin
                drive(1'b0, 2'b00, 1'b1, 32'h0F, 32'h0);
                push_exp(32'h00000088, 1'b0, 2);
            end else if (k == 1) begin
                drive(1'b0, 2'b01, 1'b0, 32'h02, 32'h0);
                push_exp(32'h00001234, 1'b0, 2);
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < 20 && n_rsp < rsp0 + 3; i++) @(negedge clk);
        #1;
        chk("b2b_rsp_count", 32'(n_rsp - rsp0), 32'h3);
        repeat (4) @(negedge clk);
        #1;
        chk("b2b_accept_count", 32'(n_acc - acc0), 32'h3);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end that sits directly upstream of the word-indexed data memory and is driven by the core's execute stage. It accepts one request at a time over a valid/ready handshake and translates byte/halfword/word accesses into word-memory reads and writes. Sub-word stores are done as read-modify-write sequences. It returns sign- or zero-extended load data, and flags misaligned or out-of-range accesses without touching memory.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words in the data memory; word index is addr[31:2].
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  loads only; 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low 8/16/32 bits are used.
- rsp_valid  output  1  one-cycle response pulse; no backpressure.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  valid with rsp_valid; misaligned, out-of-range or illegal size.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_addr  output  32  word index, zero-extended.
- mem_wdata  output  32  word to write; 0 when mem_write=0.
- mem_rdata  input  32  combinational read data from memory.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- Request fields are registered on acceptance, i.e. when req_valid & req_ready in IDLE.
- Error check at acceptance. Any one of these is an error:
  - req_size=11;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr[31:2] ≥ DEPTH_WORDS.
- On error: IDLE → RESP directly, with rsp_err=1. No mem_read or mem_write at any point.
- Otherwise IDLE → ACCESS.
- ACCESS state:
  - Load: mem_read=1. The lane is extracted from mem_rdata and registered, then → RESP.
  - Word store: mem_write=1 with mem_wdata=req_wdata, mem_read=0, then → RESP.
  - Byte/halfword store: mem_read=1. The merged word (old word with the target lane replaced) is registered, then → WRITE.
- WRITE state: mem_write=1 with mem_wdata=merged word, then → RESP.
- RESP state: rsp_valid=1 for exactly one cycle, then → IDLE.
- Lane mapping is little-endian:
  - byte k=addr[1:0] occupies bits [8k+7:8k];
  - halfword h=addr[1] occupies bits [16h+15:16h].
- Extension: bit 7 (byte) or bit 15 (halfword) is replicated unless req_unsigned=1. Word loads pass through unchanged.
- mem_addr holds the registered addr[31:2] from acceptance until the next acceptance.
- mem_read and mem_write are never high in the same cycle.
- Reset (rst low), asynchronous:
  - state = IDLE;
  - registered request fields, mem_addr and rsp_rdata = 0;
  - rsp_valid=0, rsp_err=0, mem_read=0, mem_write=0, mem_wdata=0;
  - req_ready=0 while rst is low, 1 after release.
- Reset mid-operation: any in-flight access is discarded, no response is produced, and mem_write drops in the same instant.

## Timing
- Request accepted at rising edge N.
- Load: ACCESS in cycle N..N+1, rsp_valid in cycle N+1..N+2 (2-cycle latency).
- Word store: 2 cycles. Sub-word store: 3 cycles. Error: 1 cycle.
- req_ready=0 from acceptance until state returns to IDLE. The next request is accepted no earlier than the edge ending the first IDLE cycle after RESP.
- rsp_rdata and rsp_err are registered and valid only while rsp_valid=1.
- mem_rdata is sampled at the edge that ends ACCESS.
- All memory-side outputs are combinational from state and registered fields, with no dependence on req_* inputs.

## Test plan
- Load byte, signed and unsigned:
  - Setup: word 3 preloaded with 0x8899AABB.
  - Stimulus: LB at address 0x0D.
  - Required: mem_read with mem_addr=3 for one cycle, then rsp_valid with rsp_rdata=0xFFFFFFAA two cycles after acceptance.
  - Repeat as LBU: rsp_rdata=0x000000AA. LHU at 0x0E returns 0x00008899.
- Store byte, read-modify-write:
  - Stimulus: SB at 0x0E with req_wdata=0x11, word 3 holding 0x8899AABB.
  - Required: mem_read cycle, then one mem_write cycle with mem_addr=3 and mem_wdata=0x8811AABB, then rsp_valid with rsp_rdata=0 and rsp_err=0. Total 3 cycles.
- Store word then load word:
  - Stimulus: SW to 0x10 with 0xDEADBEEF.
  - Required: single mem_write cycle (mem_addr=4), no mem_read, rsp at 2 cycles. A following LW at 0x10 returns 0xDEADBEEF.
- Errors:
  - LH at 0x0D, LW at 0x02, SW at 0x100 (index 64), and req_size=11.
  - Each gives rsp_valid with rsp_err=1 one cycle after acceptance, with no mem_read or mem_write asserted and memory unchanged.
- Reset mid-store:
  - Stimulus: drop rst during the WRITE cycle of an SB.
  - Required: mem_write deasserts immediately, no rsp_valid, target word keeps its old value, and req_ready=1 in the first cycle after rst rises.
- Back-to-back:
  - Stimulus: req_valid held high with 3 queued loads.
  - Required: each accepted exactly once, responses in order, exactly one idle-accept cycle between each RESP and the next ACCESS.
